faddsub_pipe: RTL
=================

# faddsub_pipe

Parametrised, handshaked IEEE-754 binary32 add/subtract unit. Successor to the fixed 2-stage subtractor in the FPU. Adds:
- runtime add/sub select;
- configurable pipeline depth;
- valid/ready back-pressure;
- a tag sideband;
- separate overflow and invalid flags.

It sits between the FPU issue logic and the FPU result arbiter. Rounding is round-to-nearest-even.

## Interface
Parameters:
- NUM_STAGES, 2, pipeline depth. Legal values are 2 and 3.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts this cycle.
- op  in  1  0 = x1+x2, 1 = x1−x2.
- x1, x2  in  32  binary32 operands.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- y  out  32  binary32 result.
- ovf  out  1  finite operands produced ±inf.
- inv  out  1  inf−inf, i.e. effective subtraction of infinities.
- out_tag  out  TAG_W  tag of the result.

## Operation
- A transfer occurs when in_valid & in_ready. An output handshake occurs when out_valid & out_ready.
- The global advance enable is en = !out_valid | out_ready. in_ready = en. All stage registers, including valid bits, load only when en=1.
  - This is a full-stall pipeline with no bubble collapsing.
- Effective sign of x2: x2[31]^op.
- Stage 1:
  - unpack; subnormal exponent forced to 1 with hidden bit 0;
  - 9-bit exponent difference, clamped to 31;
  - operand swap so the larger magnitude is first;
  - align with guard, round and sticky bits;
  - 27-bit add or subtract;
  - carry-out normalisation right by 1.
- Stage 2:
  - leading-zero count on the 27-bit sum;
  - left shift limited so the exponent does not go below 1 (gradual underflow);
  - RNE increment on guard/round/sticky and LSB;
  - mantissa carry bumps the exponent;
  - result zero forces exponent 0.
- Special cases, resolved in stage 1 and carried as a bypass word:
  - exactly one operand inf or NaN: that operand is returned with the quiet bit forced to 1 for NaN (sign of x2 is the effective sign).
  - both exponents 0xFF: if x2 is NaN, return quieted x2. Otherwise, if x1 is NaN, return quieted x1.
  - both inf with equal effective sign: that inf.
  - inf−inf: y=0xFFC00000, inv=1.
- Exact-zero sum: y is −0 only if both effective signs are negative, else +0.
- Rounded exponent reaches 0xFF with finite inputs: y=±inf (mantissa 0), ovf=1.
- Flags are valid only with out_valid. A handshaken result with out_valid=0 carries flags 0.

## Timing
- Latency is NUM_STAGES cycles from input handshake to out_valid, when no stall occurs. Throughput is 1 per cycle.
- NUM_STAGES=3 adds a pure output register after stage 2. Arithmetic does not move.
- out_valid=1 with out_ready=0:
  - y, flags and out_tag hold stable;
  - in_ready=0 in the same cycle (combinational from out_ready and out_valid).
- Results emerge in issue order.
- Reset, async on rstn falling:
  - every valid bit clears and out_valid=0;
  - y=0, ovf=0, inv=0, out_tag=0;
  - in-flight operations are discarded;
  - in_ready=1 while in reset.
- No output handshake is produced for operations issued before reset.

## Configuration
- FADDSUB_DENORM_EN defined: full subnormal support on inputs and outputs, as described in Operation.
- Undefined: flush-to-zero.
  - Subnormal inputs are treated as zero of the same sign.
  - Results whose exponent would be 0 are replaced by zero of the result sign.
  - The stage-2 underflow-limited shift logic is removed.

## Structure
- Package fpu_pkg holds:
  - field widths (EXP_W=8, MAN_W=23);
  - EXP_MAX=8'hFF;
  - QNAN_NEG=32'hFFC00000;
  - a typedef for unpacked operands (sign, exp, mantissa with hidden bit);
  - the op encoding constants.
- One sub-module, lzc27: a combinational 27-bit leading-zero counter with 5-bit output. An all-zero input returns 26. It is shared with the future fmul normaliser.

## Test plan
- 0x3F800000 add 0x40000000 → y=0x40400000 after exactly NUM_STAGES cycles; ovf=0, inv=0.
- Rounding ties:
  - 0x3F800000 add 0x33800000 → 0x3F800000 (tie to even);
  - 0x3F800000 add 0x33800001 → 0x3F800001.
- 0x7F7FFFFF add 0x7F7FFFFF → 0x7F800000, ovf=1.
- 0x7F800000 sub 0x7F800000 → 0xFFC00000, inv=1.
- 0x3F800000 sub 0x3F800000 → 0x00000000.
- 0x00800000 sub 0x00000001:
  - with FADDSUB_DENORM_EN → 0x007FFFFF;
  - without → 0x00800000.
- Back-pressure: issue 4 ops with tags 1..4 and hold out_ready=0 for 3 cycles mid-stream.
  - in_ready must drop.
  - No op is lost or duplicated.
  - out_tag sequence is 1,2,3,4 with correct y.
- Pull rstn low with 2 ops in flight.
  - out_valid=0 immediately; y, flags and tag are 0.
  - After release, no stale result appears and a new op completes in NUM_STAGES cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 field widths, constants and operand unpacking.
// Unpacking honours FADDSUB_DENORM_EN (subnormals kept) or flushes them to zero.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN_NEG = 32'hFFC00000;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unp_t;

    // Subnormals take exponent 1 so alignment needs no special case.
    function automatic fp_unp_t unpack(input logic sign, input logic [30:0] x);
        fp_unp_t u;
        u.sign = sign;
        u.exp  = (x[30:23] == '0) ? 8'd1 : x[30:23];
`ifdef FADDSUB_DENORM_EN
        u.man  = {x[30:23] != '0, x[22:0]};
`else
        u.man  = (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
`endif
        return u;
    endfunction
endpackage

// File: rtl/lzc27.sv
// lzc27: combinational leading-zero count of a 27-bit word; all-zero gives 26.
module lzc27 (
    input  logic [26:0] a,
    output logic [4:0]  n
);
    always_comb begin
        n = 5'd26;
        for (int i = 0; i < 27; i++)
            if (a[i]) n = 5'(26 - i);
    end
endmodule

// File: rtl/faddsub_pipe.sv
// faddsub_pipe: handshaked binary32 add/sub, RNE, 2 or 3 stage full-stall pipeline.
// FADDSUB_DENORM_EN selects gradual underflow; otherwise subnormals flush to zero.
module faddsub_pipe
    import fpu_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic             inv,
    output logic [TAG_W-1:0] out_tag
);
    logic en, s2, swap, e1ff, e2ff, nan1, nan2, inv_s;
    fp_unp_t u1, u2, a, b;
    logic [8:0] dexp;
    logic [4:0] sh;
    logic [57:0] ext;
    logic [26:0] mb, s27;
    logic [27:0] sum;
    logic [31:0] x2e, w;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    assign s2   = x2[31] ^ (op == OP_SUB);
    assign x2e  = {s2, x2[30:0]};
    assign u1   = unpack(x1[31], x1[30:0]);
    assign u2   = unpack(s2, x2[30:0]);
    assign swap = {u2.exp, u2.man} > {u1.exp, u1.man};
    assign a    = swap ? u2 : u1;
    assign b    = swap ? u1 : u2;
    assign dexp = {1'b0, a.exp} - {1'b0, b.exp};
    assign sh   = (dexp > 9'd31) ? 5'd31 : dexp[4:0];
    assign ext  = {b.man, 34'b0} >> sh;
    assign mb   = {ext[57:32], ext[31] | (|ext[30:0])};
    assign sum  = (a.sign == b.sign) ? {1'b0, a.man, 3'b0} + {1'b0, mb}
                                     : {1'b0, a.man, 3'b0} - {1'b0, mb};
    assign s27  = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];

    // Inf/NaN bypass word; x2 carries its effective sign.
    assign e1ff  = x1[30:23] == EXP_MAX;
    assign e2ff  = x2[30:23] == EXP_MAX;
    assign nan1  = e1ff & (|x1[22:0]);
    assign nan2  = e2ff & (|x2[22:0]);
    assign w     = (e2ff && (nan2 || !e1ff)) ? x2e :
                   (!e2ff || nan1)           ? x1  :
                   (x1[31] == s2)            ? x1  : QNAN_NEG;
    assign inv_s = e1ff & e2ff & !nan1 & !nan2 & (x1[31] != s2);

    logic v1, sp1, inv1, sg1, zs1;
    logic [31:0] spy1;
    logic [7:0] e1;
    logic [26:0] m1;
    logic [TAG_W-1:0] t1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            sp1  <= 1'b0;
            inv1 <= 1'b0;
            sg1  <= 1'b0;
            zs1  <= 1'b0;
            spy1 <= '0;
            e1   <= '0;
            m1   <= '0;
            t1   <= '0;
        end else if (en) begin
            v1   <= in_valid;
            sp1  <= e1ff | e2ff;
            inv1 <= inv_s;
            sg1  <= a.sign;
            zs1  <= a.sign & b.sign;
            spy1 <= w | {9'b0, |w[22:0], 22'b0};
            e1   <= a.exp + {7'b0, sum[27]};
            m1   <= s27;
            t1   <= in_tag;
        end
    end

    logic [4:0] lz, sh2;
    logic [26:0] n;
    logic [9:0] ex, ef;
    logic [24:0] mr;
    logic uflow, rnd, ov, ovf2, inv2;
    logic [31:0] y2;

    lzc27 u_lzc (.a(m1), .n(lz));

`ifdef FADDSUB_DENORM_EN
    // Stop normalising at exponent 1; the result is then subnormal.
    assign sh2   = ({3'b0, lz} < e1) ? lz : 5'(e1 - 8'd1);
    assign uflow = 1'b0;
`else
    assign sh2   = lz;
    assign uflow = ex[9] | (ex == '0);
`endif
    assign n    = m1 << sh2;
    assign ex   = {2'b0, e1} - {5'b0, sh2};
    assign rnd  = n[2] & (n[3] | n[1] | n[0]);
    assign mr   = {1'b0, n[26:3]} + {24'b0, rnd};
    assign ef   = (mr[24] | mr[23]) ? ex + {9'b0, mr[24]} : '0;
    assign ov   = ef >= 10'd255;
    assign y2   = sp1          ? spy1 :
                  (m1 == '0)   ? {zs1, 31'b0} :
                  uflow        ? {sg1, 31'b0} :
                  ov           ? {sg1, EXP_MAX, 23'b0} :
                                 {sg1, ef[7:0], mr[22:0]};
    assign ovf2 = !sp1 & (m1 != '0) & !uflow & ov;
    assign inv2 = sp1 & inv1;

    logic v2, ovf_r, inv_r;
    logic [31:0] y_r;
    logic [TAG_W-1:0] t2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2    <= 1'b0;
            y_r   <= '0;
            ovf_r <= 1'b0;
            inv_r <= 1'b0;
            t2    <= '0;
        end else if (en) begin
            v2    <= v1;
            y_r   <= y2;
            ovf_r <= ovf2 & v1;
            inv_r <= inv2 & v1;
            t2    <= t1;
        end
    end

    if (NUM_STAGES == 3) begin : g_s3
        logic v3, ovf3, inv3;
        logic [31:0] y3;
        logic [TAG_W-1:0] t3;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                v3   <= 1'b0;
                y3   <= '0;
                ovf3 <= 1'b0;
                inv3 <= 1'b0;
                t3   <= '0;
            end else if (en) begin
                v3   <= v2;
                y3   <= y_r;
                ovf3 <= ovf_r;
                inv3 <= inv_r;
                t3   <= t2;
            end
        end
        assign out_valid = v3;
        assign y         = y3;
        assign ovf       = ovf3;
        assign inv       = inv3;
        assign out_tag   = t3;
    end else begin : g_s2
        assign out_valid = v2;
        assign y         = y_r;
        assign ovf       = ovf_r;
        assign inv       = inv_r;
        assign out_tag   = t2;
    end
endmodule
